// File: rtl/usb_pkg.sv
// usb_pkg: shared constants for the USB transmit scheduler.
//   PID nibble constants (tokens, data, handshakes), scheduler state
//   encoding and a helper that forms the on-wire PID byte.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_PAYLOAD,
    ST_WAIT_EOP,
    ST_GAP
  } tx_state_e;

  // PID byte on the wire: check nibble (complement) in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// usb_rr_arbiter: round-robin arbiter for the payload requesters.
//   clk_48, rst_n : clock / asynchronous active-low reset
//   req           : request vector
//   advance       : 1 = the current grant is taken; pointer moves to it
//   grant         : one-hot winner (combinational, zero when no request)
//   grant_idx     : index of the winner
//   any           : at least one request present
// The pointer holds the last granted index; search starts one above it.
module usb_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk_48,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(NREQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: packet scheduler in front of the bit-level USB transmitter.
//   Handshake source (hs_*) has fixed top priority; NREQ payload requesters
//   are served round-robin. Sequences PID byte + payload into the
//   transmitter byte handshake and pulses completion at end of packet.
// Ports:
//   clk_48, rst_n         : 48 MHz clock, asynchronous active-low reset
//   hs_req/hs_pid/hs_done : handshake request, PID nibble, completion pulse
//   req/req_pid/req_len/req_crc : per-requester request, PID, length, CRC flag
//   pl_data/pl_rd         : per-requester payload byte, consume pulse
//   grant/done            : one-hot ownership, completion pulse
//   tx_transmit/tx_data/tx_update_crc/tx_send_crc : to transmitter
//   tx_strobe/tx_en       : from transmitter (byte accepted, line enable)
// Build option: define USB_TX_IPG_EN to insert an inter-packet gap of
//   IPG_BITS*4 clocks after tx_en falls before the next arbitration.
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 7,
  parameter int IPG_BITS = 2
) (
  input  logic                  clk_48,
  input  logic                  rst_n,
  input  logic                  hs_req,
  input  logic [3:0]            hs_pid,
  output logic                  hs_done,
  input  logic [NREQ-1:0]       req,
  input  logic [4*NREQ-1:0]     req_pid,
  input  logic [LEN_W*NREQ-1:0] req_len,
  input  logic [NREQ-1:0]       req_crc,
  input  logic [8*NREQ-1:0]     pl_data,
  output logic [NREQ-1:0]       pl_rd,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  tx_transmit,
  output logic [7:0]            tx_data,
  output logic                  tx_update_crc,
  output logic                  tx_send_crc,
  input  logic                  tx_strobe,
  input  logic                  tx_en
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  tx_state_e        state, state_nx;
  logic [IDX_W-1:0] owner_q;
  logic             is_hs_q;
  logic [3:0]       pid_q;
  logic [LEN_W-1:0] cnt_q;
  logic             crc_q;
  logic [NREQ-1:0]  grant_q;

  logic [NREQ-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             start;
  logic             rr_win;
  logic             finish;
  logic             gap_over;

  logic [3:0]       pid_arr [NREQ];
  logic [LEN_W-1:0] len_arr [NREQ];
  logic [7:0]       pl_arr  [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      pid_arr[i] = req_pid[i*4 +: 4];
      len_arr[i] = req_len[i*LEN_W +: LEN_W];
      pl_arr[i]  = pl_data[i*8 +: 8];
    end
  end

  // Arbitration happens only in IDLE with the line quiet; the handshake
  // source pre-empts the round-robin and leaves its pointer untouched.
  assign start  = (state == ST_IDLE) && !tx_en && (hs_req || arb_any);
  assign rr_win = start && !hs_req;
  assign finish = (state == ST_WAIT_EOP) && !tx_en;

  usb_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_48    (clk_48),
    .rst_n     (rst_n),
    .req       (req),
    .advance   (rr_win),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

`ifdef USB_TX_IPG_EN
  localparam bit GAP_EN   = 1'b1;
  localparam int GAP_CLKS = IPG_BITS * 4;
  localparam int GAP_W    = $clog2(GAP_CLKS + 1);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (finish) begin
      gap_cnt <= (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;
    end else if (state == ST_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign gap_over = (gap_cnt == '0);
`else
  localparam bit GAP_EN = 1'b0;
  logic ipg_unused;
  assign ipg_unused = (IPG_BITS != 0);
  assign gap_over   = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (start) state_nx = ST_PID;
      ST_PID:      if (tx_strobe) state_nx = (cnt_q == '0) ? ST_WAIT_EOP : ST_PAYLOAD;
      ST_PAYLOAD:  if (tx_strobe && cnt_q == LEN_W'(1)) state_nx = ST_WAIT_EOP;
      ST_WAIT_EOP: if (!tx_en) state_nx = GAP_EN ? ST_GAP : ST_IDLE;
      ST_GAP:      if (gap_over) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_transmit   = 1'b0;
    tx_data       = '0;
    tx_update_crc = 1'b0;
    pl_rd         = '0;
    done          = '0;
    hs_done       = 1'b0;
    unique case (state)
      ST_PID: begin
        tx_transmit = 1'b1;
        tx_data     = pid_byte(pid_q);
      end
      ST_PAYLOAD: begin
        tx_transmit    = 1'b1;
        tx_data        = pl_arr[owner_q];
        tx_update_crc  = 1'b1;
        pl_rd[owner_q] = tx_strobe;
      end
      ST_WAIT_EOP: begin
        if (!tx_en) begin
          if (is_hs_q) hs_done       = 1'b1;
          else         done[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner_q <= '0;
      is_hs_q <= 1'b0;
      pid_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        is_hs_q <= hs_req;
        if (hs_req) begin
          pid_q   <= hs_pid;
          cnt_q   <= '0;
          crc_q   <= 1'b0;
          grant_q <= '0;
        end else begin
          owner_q <= arb_idx;
          pid_q   <= pid_arr[arb_idx];
          cnt_q   <= len_arr[arb_idx];
          crc_q   <= req_crc[arb_idx];
          grant_q <= arb_grant;
        end
      end else if (state == ST_PAYLOAD && tx_strobe) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (finish) begin
        grant_q <= '0;
        crc_q   <= 1'b0;
      end
    end
  end

  assign grant       = grant_q;
  assign tx_send_crc = crc_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
module tb_usb_tx_sched;
  import usb_pkg::*;

  localparam int NREQ     = 4;
  localparam int LEN_W    = 7;
  localparam int IPG_BITS = 2;
`ifdef USB_TX_IPG_EN
  localparam int GAP_CLKS = IPG_BITS * 4;
`else
  localparam int GAP_CLKS = 0;
`endif

  logic                  clk_48 = 1'b0;
  logic                  rst_n  = 1'b0;
  logic                  hs_req = 1'b0;
  logic [3:0]            hs_pid = '0;
  logic                  hs_done;
  logic [NREQ-1:0]       req     = '0;
  logic [4*NREQ-1:0]     req_pid = '0;
  logic [LEN_W*NREQ-1:0] req_len = '0;
  logic [NREQ-1:0]       req_crc = '0;
  logic [8*NREQ-1:0]     pl_data = '0;
  logic [NREQ-1:0]       pl_rd, grant, done;
  logic                  tx_transmit, tx_update_crc, tx_send_crc;
  logic [7:0]            tx_data;
  logic                  tx_strobe = 1'b0;
  logic                  tx_en     = 1'b0;

  always #10 clk_48 = ~clk_48;

  usb_tx_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .IPG_BITS(IPG_BITS)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
    .req(req), .req_pid(req_pid), .req_len(req_len), .req_crc(req_crc),
    .pl_data(pl_data), .pl_rd(pl_rd), .grant(grant), .done(done),
    .tx_transmit(tx_transmit), .tx_data(tx_data), .tx_update_crc(tx_update_crc),
    .tx_send_crc(tx_send_crc), .tx_strobe(tx_strobe), .tx_en(tx_en)
  );

  int checks = 0;
  int passed = 0;

  // requester / handshake environment
  logic [7:0] pay [NREQ][8];
  int rdptr [NREQ];
  int cool  [NREQ];
  int hs_cool, cool_max;
  bit auto_mode, hs_en;
  logic [NREQ-1:0] en_mask;
  // transmitter emulation: 0 line idle, 1 sending bytes, 2 CRC/EOP tail
  int ln, wcnt;
  // outputs seen in the previous cycle
  logic s_transmit, s_send_crc, s_hs_done;
  logic [NREQ-1:0] s_done, s_rd, prev_grant;
  logic prev_tx_en, prev_transmit;
  // behavioural model of the scheduler
  bit m_busy;
  int m_owner, m_idx, m_last, m_gap;
  bit m_crc;
  logic [7:0] m_bytes[$];
  // per-scenario logs
  logic [7:0] log_byte[$];
  logic log_upd[$];
  int grant_log[$];
  int rd_count, done_cnt, hs_cnt;
  bit crc_seen;
  int cyc, fall_cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_req(int i, logic [3:0] pid, int len, bit crc);
    req_pid[i*4 +: 4]         = pid;
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    req_crc[i]                = crc;
    for (int b = 0; b < 8; b++) pay[i][b] = 8'($urandom);
    rdptr[i] = 0;
    req[i]   = 1'b1;
  endtask

  function automatic logic [3:0] pick_hs();
    case ($urandom_range(0, 2))
      0:       return PID_ACK;
      1:       return PID_NAK;
      default: return PID_STALL;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (s_done[i]) begin req[i] = 1'b0; cool[i] = $urandom_range(0, cool_max); end
      if (s_rd[i]) rdptr[i]++;
    end
    if (s_hs_done) begin hs_req = 1'b0; hs_cool = $urandom_range(5, 60); end
    if (auto_mode) begin
      for (int i = 0; i < NREQ; i++)
        if (en_mask[i] && !req[i]) begin
          if (cool[i] == 0) set_req(i, 4'($urandom), $urandom_range(0, 6), 1'($urandom));
          else cool[i]--;
        end
      if (hs_en && !hs_req) begin
        if (hs_cool == 0) begin hs_req = 1'b1; hs_pid = pick_hs(); end
        else hs_cool--;
      end
    end
    tx_strobe = 1'b0;
    case (ln)
      0: if (s_transmit) begin tx_en = 1'b1; ln = 1; wcnt = $urandom_range(1, 3); end
      1: if (!s_transmit) begin ln = 2; wcnt = (s_send_crc ? 3 : 0) + 1; end
         else if (wcnt == 0) begin tx_strobe = 1'b1; wcnt = $urandom_range(1, 3); end
         else wcnt--;
      default: if (wcnt == 0) begin tx_en = 1'b0; ln = 0; end else wcnt--;
    endcase
    for (int i = 0; i < NREQ; i++) pl_data[i*8 +: 8] = pay[i][rdptr[i] % 8];
  endtask

  task automatic sample();
    logic [NREQ-1:0] e_grant = '0, e_rd = '0, e_done = '0;
    logic e_hs = 1'b0, e_tx = 1'b0, e_upd = 1'b0, e_send = 1'b0;
    logic [7:0] e_data = '0;
    int len, j;
    bit found;
    if (m_busy) begin
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      e_send = m_crc;
      if (m_idx < m_bytes.size()) begin
        e_tx   = 1'b1;
        e_data = m_bytes[m_idx];
        e_upd  = (m_idx > 0);
        if (tx_strobe && m_idx > 0 && m_owner >= 0) e_rd[m_owner] = 1'b1;
      end else if (!tx_en) begin
        if (m_owner >= 0) e_done[m_owner] = 1'b1;
        else e_hs = 1'b1;
      end
    end
    chk("grant", grant, e_grant);
    chk("tx_transmit", tx_transmit, e_tx);
    chk("tx_send_crc", tx_send_crc, e_send);
    chk("pl_rd", pl_rd, e_rd);
    chk("done", done, e_done);
    chk("hs_done", hs_done, e_hs);
    if (e_tx) begin
      chk("tx_data", tx_data, e_data);
      chk("tx_update_crc", tx_update_crc, e_upd);
    end
    // logs for the directed scenarios
    if (tx_strobe && tx_transmit) begin log_byte.push_back(tx_data); log_upd.push_back(tx_update_crc); end
    rd_count += $countones(pl_rd);
    done_cnt += $countones(done) + int'(hs_done);
    hs_cnt   += int'(hs_done);
    if (tx_send_crc) crc_seen = 1'b1;
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NREQ; i++) if (grant[i]) grant_log.push_back(i);
    if (prev_tx_en && !tx_en) fall_cyc = cyc;
`ifdef USB_TX_IPG_EN
    if (tx_transmit && !prev_transmit) chk("ipg_gap", (cyc - fall_cyc) >= GAP_CLKS, 1'b1);
`endif
    // model advance: one clock of the scheduler's externally visible rules
    if (!m_busy) begin
      if (m_gap > 0) m_gap--;
      else if (!tx_en && (hs_req || req != '0)) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_bytes.delete();
        if (hs_req) begin
          m_owner = -1;
          m_crc   = 1'b0;
          m_bytes.push_back({~hs_pid, hs_pid});
        end else begin
          found = 1'b0;
          j = 0;
          for (int k = 1; k <= NREQ; k++)
            if (!found && req[(m_last + k) % NREQ]) begin found = 1'b1; j = (m_last + k) % NREQ; end
          m_owner = j;
          m_last  = j;
          m_crc   = req_crc[j];
          m_bytes.push_back({~req_pid[j*4 +: 4], req_pid[j*4 +: 4]});
          len = int'(req_len[j*LEN_W +: LEN_W]);
          for (int b = 0; b < len; b++) m_bytes.push_back(pay[j][b]);
        end
      end
    end else if (m_idx < m_bytes.size()) begin
      if (tx_strobe) m_idx++;
    end else if (!tx_en) begin
      m_busy = 1'b0;
      m_gap  = GAP_CLKS;
    end
    s_transmit    = tx_transmit;
    s_send_crc    = tx_send_crc;
    s_hs_done     = hs_done;
    s_done        = done;
    s_rd          = pl_rd;
    prev_grant    = grant;
    prev_tx_en    = tx_en;
    prev_transmit = tx_transmit;
    cyc++;
  endtask

  // entered and left at posedge+1
  task automatic step();
    drive();
    @(negedge clk_48);
    sample();
    @(posedge clk_48);
    #1;
  endtask

  task automatic run_until_done(int n, int budget, string what);
    int b = 0;
    while (done_cnt < n && b < budget) begin step(); b++; end
    if (done_cnt < n) begin
      checks++;
      $display("FAIL %s timeout: got %0d packets required %0d", what, done_cnt, n);
    end
  endtask

  task automatic clear_logs();
    log_byte.delete(); log_upd.delete(); grant_log.delete();
    rd_count = 0; done_cnt = 0; hs_cnt = 0; crc_seen = 1'b0;
  endtask

  task automatic do_reset(bit keep_req);
    rst_n = 1'b0; tx_en = 1'b0; tx_strobe = 1'b0; ln = 0; auto_mode = 1'b0;
    if (!keep_req) begin req = '0; hs_req = 1'b0; end
    for (int i = 0; i < NREQ; i++) begin rdptr[i] = 0; cool[i] = 0; end
    s_transmit = 0; s_send_crc = 0; s_hs_done = 0; s_done = '0; s_rd = '0;
    prev_grant = '0; prev_tx_en = 0; prev_transmit = 0;
    @(negedge clk_48);
    chk("reset_outputs", {grant, pl_rd, done, hs_done, tx_transmit, tx_data, tx_update_crc, tx_send_crc}, '0);
    @(posedge clk_48);
    #1;
    rst_n  = 1'b1;
    m_busy = 1'b0; m_gap = 0; m_last = NREQ - 1;
    clear_logs();
  endtask

  initial begin
    int b;
    cyc = 0; fall_cyc = -1000; cool_max = 0; hs_cool = 0; hs_en = 0; en_mask = '0;
    for (int i = 0; i < NREQ; i++) for (int k = 0; k < 8; k++) pay[i][k] = '0;
    @(posedge clk_48);
    #1;
    do_reset(1'b0);

    // handshake and requester 1 arrive together: handshake first
    hs_req = 1'b1; hs_pid = PID_ACK;
    set_req(1, PID_DATA0, 2, 1'b0);
    run_until_done(2, 600, "hs_first");
    chk("hs_first_byte", log_byte[0], 8'hD2);
    chk("hs_then_data_pid", log_byte[1], 8'hC3);
    chk("hs_done_count", hs_cnt, 1);
    chk("hs_then_grant1", grant_log[0], 1);

    // three requesters held: round-robin order from a fresh pointer
    do_reset(1'b0);
    auto_mode = 1'b1; en_mask = 4'b0111; hs_en = 1'b0; cool_max = 0;
    run_until_done(4, 1500, "rr_order");
    chk("rr_grant_0", grant_log[0], 0);
    chk("rr_grant_1", grant_log[1], 1);
    chk("rr_grant_2", grant_log[2], 2);
    chk("rr_grant_3", grant_log[3], 0);

    // DATA0 with 3 bytes and CRC
    do_reset(1'b0);
    set_req(2, PID_DATA0, 3, 1'b1);
    pay[2][0] = 8'h11; pay[2][1] = 8'h22; pay[2][2] = 8'h33;
    run_until_done(1, 600, "data0_len3");
    chk("len3_count", log_byte.size(), 4);
    chk("len3_b0", log_byte[0], 8'hC3);
    chk("len3_b1", log_byte[1], 8'h11);
    chk("len3_b2", log_byte[2], 8'h22);
    chk("len3_b3", log_byte[3], 8'h33);
    chk("len3_upd", {log_upd[0], log_upd[1], log_upd[2], log_upd[3]}, 4'b0111);
    chk("len3_pl_rd", rd_count, 3);
    chk("len3_crc", crc_seen, 1'b1);

    // zero-length DATA1 with CRC
    do_reset(1'b0);
    set_req(0, PID_DATA1, 0, 1'b1);
    run_until_done(1, 600, "zlp");
    chk("zlp_count", log_byte.size(), 1);
    chk("zlp_byte", log_byte[0], 8'h4B);
    chk("zlp_crc", crc_seen, 1'b1);
    chk("zlp_rd", rd_count, 0);

    // reset in the middle of a payload, request still held afterwards
    do_reset(1'b0);
    set_req(3, PID_DATA1, 5, 1'b0);
    b = 0;
    while (rd_count < 1 && b < 400) begin step(); b++; end
    chk("midpkt_reached_payload", rd_count >= 1, 1'b1);
    do_reset(1'b1);
    run_until_done(1, 800, "regrant");
    chk("regrant_owner", grant_log[0], 3);
    chk("regrant_bytes", log_byte.size(), 6);

    // randomized traffic with the handshake source active
    do_reset(1'b0);
    auto_mode = 1'b1; en_mask = '1; hs_en = 1'b1; cool_max = 12; hs_cool = 10;
    repeat (4000) step();
    chk("random_progress", done_cnt > 20, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
